// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan controller: FSM state encoding,
// counter-width derivation and field positions inside the packed pixel word.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_t;

  // pix_data = {r0,g0,b0,r1,g1,b1}; a field index f selects pix_data[f*PWM_BITS +: PWM_BITS]
  localparam int unsigned FLD_B1     = 0;
  localparam int unsigned FLD_G1     = 1;
  localparam int unsigned FLD_R1     = 2;
  localparam int unsigned FLD_B0     = 3;
  localparam int unsigned FLD_G0     = 4;
  localparam int unsigned FLD_R0     = 5;
  localparam int unsigned NUM_FIELDS = 6;

  // Bits needed to index n items; never below 1 so degenerate sizes stay legal
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// DISPLAY-phase timer: load an on-time in cycles, count down, flag the last cycle.
module hub75_oe_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] cycles,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= cycles - 1'b1;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan/refresh controller: BCM row scan with frame-boundary image switching.
// state      | meaning
// ST_FETCH   | present first pixel address of the row
// ST_SHIFT   | two cycles per column: load colour bits, then raise clk_out
// ST_BLANK   | panel dark, row address updated
// ST_LATCH   | latch pulse, panel still dark
// ST_DISPLAY | oe low for BASE_OE<<plane cycles
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter  int unsigned COLS       = 64,
  parameter  int unsigned ROW_ADDR_W = 5,
  parameter  int unsigned PWM_BITS   = 4,
  parameter  int unsigned BASE_OE    = 8,
  parameter  int unsigned IMG_W      = 2,
  localparam int unsigned COL_W      = index_width(COLS),
  localparam int unsigned PIX_W      = NUM_FIELDS * PWM_BITS,
  localparam int unsigned PADDR_W    = IMG_W + ROW_ADDR_W + COL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  img_req,
  input  logic [IMG_W-1:0]      img_sel,
  output logic                  img_ack,
  output logic [IMG_W-1:0]      cur_img,
  output logic [PADDR_W-1:0]    pix_addr,
  input  logic [PIX_W-1:0]      pix_data,
  output logic                  r0,
  output logic                  g0,
  output logic                  b0,
  output logic                  r1,
  output logic                  g1,
  output logic                  b1,
  output logic [ROW_ADDR_W-1:0] addr,
  output logic                  clk_out,
  output logic                  latch,
  output logic                  oe,
  output logic                  frame_start
);

  localparam int unsigned PLANE_W = index_width(PWM_BITS);
  localparam int unsigned OE_MAX  = BASE_OE << (PWM_BITS - 1);
  localparam int unsigned OE_W    = $clog2(OE_MAX + 1);

  localparam logic [PLANE_W-1:0]    LAST_PLANE = PLANE_W'(PWM_BITS - 1);
  localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_ADDR_W-1:0] LAST_ROW   = '1;

  scan_state_t           state_q, state_d;
  logic                  armed_q;
  logic [ROW_ADDR_W-1:0] row_q, row_d;
  logic [PLANE_W-1:0]    plane_q, plane_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic                  phase_q, phase_d;
  logic [IMG_W-1:0]      img_q;
  logic                  ack_q;
  logic [ROW_ADDR_W-1:0] addr_q;
  logic [NUM_FIELDS-1:0] rgb_q;
  logic [NUM_FIELDS-1:0] plane_bit;
  logic [COL_W-1:0]      rd_col;
  logic [OE_W-1:0]       oe_cycles;
  logic                  oe_load;
  logic                  oe_done;
  logic                  frame_end;

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_plane_bit
    logic [PWM_BITS-1:0] field;
    assign field        = pix_data[f*PWM_BITS +: PWM_BITS];
    assign plane_bit[f] = field[plane_q];
  end

  assign oe_cycles = OE_W'(BASE_OE) << plane_q;

  hub75_oe_timer #(
    .CNT_W (OE_W)
  ) u_oe_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (oe_load),
    .cycles (oe_cycles),
    .done   (oe_done)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    plane_d   = plane_q;
    col_d     = col_q;
    phase_d   = phase_q;
    oe_load   = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      // Held for one idle cycle after reset so frame_start marks a real FETCH
      ST_FETCH: begin
        if (armed_q) begin
          state_d = ST_SHIFT;
          col_d   = '0;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          col_d = col_q + 1'b1;
          if (col_q == LAST_COL) state_d = ST_BLANK;
        end
      end
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: begin
        state_d = ST_DISPLAY;
        oe_load = 1'b1;
      end
      ST_DISPLAY: begin
        if (oe_done) begin
          state_d = ST_FETCH;
          if (plane_q == LAST_PLANE) begin
            plane_d   = '0;
            row_d     = row_q + 1'b1;
            frame_end = (row_q == LAST_ROW);
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      armed_q <= 1'b0;
      row_q   <= '0;
      plane_q <= '0;
      col_q   <= '0;
      phase_q <= 1'b0;
      img_q   <= '0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      row_q   <= row_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      ack_q   <= frame_end && img_req;
      if (frame_end && img_req)             img_q  <= img_sel;
      if (state_q == ST_BLANK)              addr_q <= row_q;
      if (state_q == ST_SHIFT && !phase_q)  rgb_q  <= plane_bit;
    end
  end

  // Address runs one column ahead so RAM data lands on the next phase-0 cycle
  assign rd_col      = (state_q == ST_SHIFT) ? col_q + 1'b1 : '0;
  assign pix_addr    = {img_q, row_q, rd_col};
  assign cur_img     = img_q;
  assign img_ack     = ack_q;
  assign addr        = addr_q;
  assign oe          = (state_q != ST_DISPLAY);
  assign latch       = (state_q == ST_LATCH);
  assign clk_out     = (state_q == ST_SHIFT) && phase_q;
  assign frame_start = armed_q && (state_q == ST_FETCH) && (row_q == '0) && (plane_q == '0);

  assign r0 = rgb_q[FLD_R0];
  assign g0 = rgb_q[FLD_G0];
  assign b0 = rgb_q[FLD_B0];
  assign r1 = rgb_q[FLD_R1];
  assign g1 = rgb_q[FLD_G1];
  assign b1 = rgb_q[FLD_B1];

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: timeline model of a frame computed from segment lengths.
module tb_hub75_scan_ctrl;

  localparam int COLS       = 4;
  localparam int ROW_ADDR_W = 2;
  localparam int PWM_BITS   = 2;
  localparam int BASE_OE    = 2;
  localparam int IMG_W      = 2;
  localparam int ROWS       = 4;
  localparam int FRAME      = 112;

  logic        clk, rst, img_req;
  logic [1:0]  img_sel, cur_img, addr;
  logic        img_ack, r0, g0, b0, r1, g1, b1, clk_out, latch, oe, frame_start;
  logic [5:0]  pix_addr;
  logic [11:0] pix_data;
  logic [11:0] mem [64];

  int checks, failures;
  int t, cur_img_m, pend_sel;
  bit first_frame, exp_ack, pend_req;

  hub75_scan_ctrl #(
    .COLS(COLS), .ROW_ADDR_W(ROW_ADDR_W), .PWM_BITS(PWM_BITS), .BASE_OE(BASE_OE), .IMG_W(IMG_W)
  ) dut (
    .clk(clk), .rst(rst), .img_req(img_req), .img_sel(img_sel), .img_ack(img_ack),
    .cur_img(cur_img), .pix_addr(pix_addr), .pix_data(pix_data),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addr(addr), .clk_out(clk_out), .latch(latch), .oe(oe), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) pix_data <= mem[pix_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0d", t);
    $fatal(1, "watchdog");
  end

  // Find row, plane and offset inside the (row,plane) segment for frame cycle tt
  function automatic void locate(input int tt, output int row, output int plane, output int off);
    int rem;
    rem = tt; row = 0; plane = 0; off = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < PWM_BITS; p++) begin
        int len;
        len = 3 + 2*COLS + (BASE_OE << p);
        if (rem >= 0 && rem < len) begin row = r; plane = p; off = rem; end
        rem -= len;
      end
    end
  endfunction

  function automatic logic [5:0] exp_rgb(input int img, input int row, input int col, input int plane);
    logic [5:0]  a;
    logic [11:0] w;
    logic [5:0]  res;
    a = 6'(img*16 + row*4 + col);
    for (int f = 0; f < 6; f++) begin
      w = mem[a] >> (f*PWM_BITS + plane);
      res[f] = w[0];
    end
    return res;
  endfunction

  function automatic int exp_addr(input int row, input int plane, input int off);
    if (off >= 2*COLS + 2 || plane > 0) return row;
    if (row == 0 && first_frame) return 0;
    return (row + ROWS - 1) % ROWS;
  endfunction

  task automatic tick();
    if (t == FRAME - 1) begin pend_req = img_req; pend_sel = int'(img_sel); end
    @(negedge clk);
    t = (t + 1) % FRAME;
    exp_ack = 1'b0;
    if (t == 0) begin
      first_frame = 1'b0;
      if (pend_req) begin exp_ack = 1'b1; cur_img_m = pend_sel; end
      pend_req = 1'b0;
    end
  endtask

  task automatic restart_model();
    t = 0; first_frame = 1'b1; cur_img_m = 0; exp_ack = 1'b0; pend_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL reset_oe got=%b want=1", oe); end
    checks++; if (latch !== 1'b0 || clk_out !== 1'b0) begin failures++; $display("FAIL reset_latch_clk got=%b%b want=00", latch, clk_out); end
    checks++; if ({r0,g0,b0,r1,g1,b1} !== 6'b0) begin failures++; $display("FAIL reset_rgb got=%b want=000000", {r0,g0,b0,r1,g1,b1}); end
    checks++; if (addr !== 2'd0 || pix_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got=%0d/%0d want=0/0", addr, pix_addr); end
    checks++; if (cur_img !== 2'd0 || img_ack !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("FAIL reset_img got=%0d ack=%b fs=%b want=0 0 0", cur_img, img_ack, frame_start); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL first_frame_start got=%b want=1", frame_start); end
    restart_model();
  endtask

  task automatic test_pixel();
    int row, plane, off;
    for (int n = 0; n < FRAME; n++) begin
      tick();
      locate(t, row, plane, off);
      if (row == 1 && off == 6) begin
        checks++;
        if (r1 !== ((plane == 0) ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL pixel_r1 plane=%0d got=%b want=%b", plane, r1, (plane != 0));
        end
      end
    end
  endtask

  task automatic test_scan(input int frames);
    int row, plane, off, col;
    bit e_oe, e_latch, e_clk;
    for (int n = 0; n < frames*FRAME; n++) begin
      tick();
      locate(t, row, plane, off);
      e_oe    = (off < 2*COLS + 3);
      e_latch = (off == 2*COLS + 2);
      e_clk   = (off >= 2 && off <= 2*COLS && (off % 2 == 0));
      checks++; if (oe !== e_oe) begin failures++; $display("FAIL scan_oe t=%0d got=%b want=%b", t, oe, e_oe); end
      checks++; if (latch !== e_latch) begin failures++; $display("FAIL scan_latch t=%0d got=%b want=%b", t, latch, e_latch); end
      checks++; if (clk_out !== e_clk) begin failures++; $display("FAIL scan_clk_out t=%0d got=%b want=%b", t, clk_out, e_clk); end
      checks++; if (frame_start !== (t == 0)) begin failures++; $display("FAIL scan_frame_start t=%0d got=%b want=%b", t, frame_start, (t == 0)); end
      checks++; if (addr !== 2'(exp_addr(row, plane, off))) begin failures++; $display("FAIL scan_addr t=%0d got=%0d want=%0d", t, addr, exp_addr(row, plane, off)); end
      checks++; if (img_ack !== exp_ack || cur_img !== 2'(cur_img_m)) begin failures++; $display("FAIL scan_img t=%0d got=%b/%0d want=%b/%0d", t, img_ack, cur_img, exp_ack, cur_img_m); end
      if (off == 0) begin
        checks++;
        if (pix_addr !== 6'(cur_img_m*16 + row*4)) begin failures++; $display("FAIL scan_pix_addr t=%0d got=%0d want=%0d", t, pix_addr, cur_img_m*16 + row*4); end
      end
      if (e_clk) begin
        col = (off - 1) / 2;
        checks++;
        if ({r0,g0,b0,r1,g1,b1} !== exp_rgb(cur_img_m, row, col, plane)) begin
          failures++; $display("FAIL scan_rgb t=%0d got=%b want=%b", t, {r0,g0,b0,r1,g1,b1}, exp_rgb(cur_img_m, row, col, plane));
        end
      end
    end
  endtask

  task automatic test_protocol();
    int run, nruns, lat_len;
    logic prev_oe;
    logic [1:0] prev_addr;
    while (t != FRAME - 1) tick();
    prev_oe = oe; prev_addr = addr; run = 0; nruns = 0; lat_len = 0;
    for (int n = 0; n < 2*FRAME + 1; n++) begin
      tick();
      checks++; if (oe === 1'b0 && latch === 1'b1) begin failures++; $display("FAIL proto_oe_latch t=%0d got=oe0,latch1 want=no overlap", t); end
      if (prev_oe === 1'b0 || oe === 1'b0) begin
        checks++; if (addr !== prev_addr) begin failures++; $display("FAIL proto_addr_stable t=%0d got=%0d want=%0d", t, addr, prev_addr); end
      end
      if (oe === 1'b0) begin
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL proto_clk_in_display t=%0d got=%b want=0", t, clk_out); end
      end
      if (latch === 1'b1) lat_len++;
      else if (lat_len > 0) begin
        checks++; if (lat_len != 1) begin failures++; $display("FAIL proto_latch_width got=%0d want=1", lat_len); end
        lat_len = 0;
      end
      if (oe === 1'b0) run++;
      else if (run > 0) begin
        checks++; if (run != (BASE_OE << (nruns % 2))) begin failures++; $display("FAIL proto_oe_len run=%0d got=%0d want=%0d", nruns, run, BASE_OE << (nruns % 2)); end
        nruns++; run = 0;
      end
      prev_oe = oe; prev_addr = addr;
    end
    checks++; if (nruns != 2*ROWS*PWM_BITS) begin failures++; $display("FAIL proto_run_count got=%0d want=%0d", nruns, 2*ROWS*PWM_BITS); end
  endtask

  task automatic test_img_switch();
    int req_at, change_at, sel_first, sel_final;
    while (t != 0) tick();
    for (int rnd = 0; rnd < 4; rnd++) begin
      if (rnd == 0) begin req_at = 30; sel_first = 3; change_at = 50; sel_final = 2; end
      else begin
        req_at    = $urandom_range(1, 100);
        change_at = $urandom_range(req_at, 110);
        sel_first = $urandom_range(0, 3);
        sel_final = (rnd == 2) ? cur_img_m : (rnd == 3) ? 3 : $urandom_range(0, 3);
      end
      for (int n = 0; n < FRAME; n++) begin
        if (t == req_at)    begin img_req = 1'b1; img_sel = 2'(sel_first); end
        if (t == change_at) img_sel = 2'(sel_final);
        tick();
        checks++; if (img_ack !== exp_ack) begin failures++; $display("FAIL img_ack rnd=%0d t=%0d got=%b want=%b", rnd, t, img_ack, exp_ack); end
        checks++; if (cur_img !== 2'(cur_img_m)) begin failures++; $display("FAIL img_cur rnd=%0d t=%0d got=%0d want=%0d", rnd, t, cur_img, cur_img_m); end
        if (t == 0) begin
          checks++; if (cur_img !== 2'(sel_final)) begin failures++; $display("FAIL img_final rnd=%0d got=%0d want=%0d", rnd, cur_img, sel_final); end
          checks++; if (pix_addr[5:4] !== 2'(sel_final)) begin failures++; $display("FAIL img_pix_addr rnd=%0d got=%0d want=%0d", rnd, pix_addr[5:4], sel_final); end
          img_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int row, plane, off, guard, tplane, toff;
    tplane = $urandom_range(0, 1);
    toff   = 2*COLS + 3 + $urandom_range(0, (BASE_OE << tplane) - 1);
    guard  = 0;
    do begin
      tick(); locate(t, row, plane, off); guard++;
    end while (!(row == 2 && plane == tplane && off == toff) && guard < 2*FRAME);
    checks++; if (guard >= 2*FRAME) begin failures++; $display("FAIL mid_reset_locate got=timeout want=row2 display"); end
    rst = 1'b0;
    #1;
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL mid_reset_oe got=%b want=1", oe); end
    checks++; if (addr !== 2'd0) begin failures++; $display("FAIL mid_reset_addr got=%0d want=0", addr); end
    checks++; if ({r0,g0,b0,r1,g1,b1} !== 6'b0) begin failures++; $display("FAIL mid_reset_rgb got=%b want=000000", {r0,g0,b0,r1,g1,b1}); end
    checks++; if (cur_img !== 2'd0) begin failures++; $display("FAIL mid_reset_cur_img got=%0d want=0", cur_img); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1 || pix_addr !== 6'd0) begin failures++; $display("FAIL mid_reset_restart got=fs%b pa%0d want=fs1 pa0", frame_start, pix_addr); end
    restart_model();
  endtask

  task automatic test_no_req();
    int row, plane, off;
    img_req = 1'b0;
    img_sel = 2'($urandom_range(1, 3));
    for (int n = 0; n < 2*FRAME; n++) begin
      tick();
      locate(t, row, plane, off);
      checks++; if (img_ack !== 1'b0 || cur_img !== 2'd0) begin failures++; $display("FAIL noreq_img t=%0d got=%b/%0d want=0/0", t, img_ack, cur_img); end
      checks++; if (frame_start !== (t == 0)) begin failures++; $display("FAIL noreq_frame_start t=%0d got=%b want=%b", t, frame_start, (t == 0)); end
      checks++; if (addr !== 2'(exp_addr(row, plane, off))) begin failures++; $display("FAIL noreq_addr t=%0d got=%0d want=%0d", t, addr, exp_addr(row, plane, off)); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; img_req = 1'b0; img_sel = 2'd0; pend_sel = 0;
    restart_model();
    for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);
    mem[6][5:4] = 2'b10;
    test_reset();
    test_pixel();
    test_scan(2);
    test_protocol();
    test_img_switch();
    test_mid_reset();
    test_no_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
